// File: rtl/bin_a_bcd_display_if.sv
// Bus-side interface of the binary-to-BCD display converter.
// The master is the store path plus the display sink. The slave is the converter.
interface bin_a_bcd_display_if;
   logic [31:0] dato_i;
   logic        we_i;
   logic [31:0] dato_o;
   logic        we_o;
   logic        busy_o;
   logic        ovf_o;
   logic        sign_o;

   modport master (
      output dato_i, we_i,
      input  dato_o, we_o, busy_o, ovf_o, sign_o
   );

   modport slave (
      input  dato_i, we_i,
      output dato_o, we_o, busy_o, ovf_o, sign_o
   );
endinterface

// File: rtl/bin_a_bcd_display.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock).
// It sits in front of the 7-segment display and emits a one-cycle write strobe
// carrying the packed BCD word. Values too large for DIGITS digits saturate to
// all-9s and raise ovf_o. A one-deep pending buffer holds the latest store that
// arrives while a conversion is running.
// Optional macro BIN_BCD_SIGNED_EN: treat the input as two's complement,
// convert its magnitude and report the sign on sign_o.
module bin_a_bcd_display #(
   parameter int WIDTH_IN = 16,
   parameter int DIGITS   = 4
) (
   input  logic               clk_i,
   input  logic               reset_n_i,
   bin_a_bcd_display_if.slave bus
);

   // Scratch holds every digit the operand can produce, so nothing is truncated.
   localparam int SCR_D  = (WIDTH_IN + 2) / 3 + 1;
   localparam int SCR_W  = 4 * SCR_D;
   localparam int PACK_D = (DIGITS < SCR_D) ? DIGITS : SCR_D;
   localparam int CNT_W  = $clog2(WIDTH_IN + 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t              state, state_nxt;
   logic [SCR_W-1:0]    scratch;
   logic [WIDTH_IN-1:0] operand;
   logic [CNT_W-1:0]    count;
   logic [WIDTH_IN-1:0] pend_val;
   logic                pend_vld;
   logic                sign_cur;
   logic [31:0]         dato;
   logic                ovf;
   logic                sign;
   logic                load;
   logic                load_from_pend;
   logic [WIDTH_IN-1:0] load_raw;

   // Add 3 to every digit that is 5 or more, ahead of the next doubling.
   function automatic logic [SCR_W-1:0] add3(input logic [SCR_W-1:0] s);
      logic [SCR_W-1:0] r;
      r = s;
      for (int k = 0; k < SCR_D; k++)
         if (s[4*k +: 4] >= 4'd5) r[4*k +: 4] = s[4*k +: 4] + 4'd3;
      return r;
   endfunction

   // True when any digit above the displayed range is nonzero.
   function automatic logic over(input logic [SCR_W-1:0] s);
      logic r;
      r = 1'b0;
      for (int k = DIGITS; k < SCR_D; k++)
         if (s[4*k +: 4] != 4'd0) r = 1'b1;
      return r;
   endfunction

   // Saturate to all-9s on overflow, otherwise keep the low DIGITS digits.
   function automatic logic [31:0] pack(input logic [SCR_W-1:0] s);
      logic [31:0] r;
      r = '0;
      if (over(s)) begin
         for (int k = 0; k < DIGITS; k++) r[4*k +: 4] = 4'd9;
      end else begin
         for (int k = 0; k < PACK_D; k++) r[4*k +: 4] = s[4*k +: 4];
      end
      return r;
   endfunction

   // Value actually converted. The most-negative input maps to its unsigned magnitude.
   function automatic logic [WIDTH_IN-1:0] magnitude(input logic [WIDTH_IN-1:0] raw);
`ifdef BIN_BCD_SIGNED_EN
      return raw[WIDTH_IN-1] ? (~raw + 1'b1) : raw;
`else
      return raw;
`endif
   endfunction

   // Input bits above WIDTH_IN are ignored by design.
   if (WIDTH_IN < 32) begin : g_hi
      logic unused_hi;
      assign unused_hi = ^bus.dato_i[31:WIDTH_IN];
   end

   // State register.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) state <= IDLE;
      else            state <= state_nxt;
   end

   // Next state and operand-load selection. A fresh store wins over a pending one.
   always_comb begin
      state_nxt      = state;
      load           = 1'b0;
      load_from_pend = 1'b0;
      load_raw       = pend_val;
      case (state)
         IDLE: begin
            if (bus.we_i) begin
               load      = 1'b1;
               load_raw  = bus.dato_i[WIDTH_IN-1:0];
               state_nxt = SHIFT;
            end else if (pend_vld) begin
               load           = 1'b1;
               load_from_pend = 1'b1;
               state_nxt      = SHIFT;
            end
         end
         SHIFT:   if (count == CNT_W'(WIDTH_IN)) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Conversion datapath, result registers and the pending buffer.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         scratch  <= '0;
         operand  <= '0;
         count    <= '0;
         pend_val <= '0;
         pend_vld <= 1'b0;
         sign_cur <= 1'b0;
         dato     <= '0;
         ovf      <= 1'b0;
         sign     <= 1'b0;
      end else begin
         if (load) begin
            operand <= magnitude(load_raw);
            scratch <= '0;
            count   <= '0;
`ifdef BIN_BCD_SIGNED_EN
            sign_cur <= load_raw[WIDTH_IN-1];
`else
            sign_cur <= 1'b0;
`endif
         end else if (state == SHIFT) begin
            if (count != CNT_W'(WIDTH_IN)) begin
               {scratch, operand} <= {add3(scratch), operand} << 1;
               count              <= count + 1'b1;
            end else begin
               dato <= pack(scratch);
               ovf  <= over(scratch);
               sign <= sign_cur;
            end
         end
         if (bus.we_i && state != IDLE) begin
            pend_val <= bus.dato_i[WIDTH_IN-1:0];
            pend_vld <= 1'b1;
         end else if (load_from_pend) begin
            pend_vld <= 1'b0;
         end
      end
   end

   assign bus.dato_o = dato;
   assign bus.we_o   = (state == DONE);
   assign bus.busy_o = (state != IDLE);
   assign bus.ovf_o  = ovf;
   assign bus.sign_o = sign;

endmodule

// File: tb/tb_bin_a_bcd_display.sv
// Scoreboard bench for bin_a_bcd_display with default parameters (16 bits, 4 digits).
// Expected results come from an arithmetic reference model. They are queued
// when a store is driven and compared when we_o pulses.
module tb_bin_a_bcd_display;

   typedef struct packed {
      logic [31:0] dato;
      logic        ovf;
      logic        sign;
   } exp_t;

   logic clk;
   logic rst_n;
   int   errors;
   int   checks;
   exp_t q[$];

   bin_a_bcd_display_if bif();

   bin_a_bcd_display #(.WIDTH_IN(16), .DIGITS(4)) dut (
      .clk_i     (clk),
      .reset_n_i (rst_n),
      .bus       (bif.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference model: arithmetic magnitude, saturation at 9999, BCD built by division.
   function automatic exp_t model(input logic [31:0] v);
      exp_t        e;
      logic [15:0] raw;
      int unsigned mag;
      int unsigned t;
      raw    = v[15:0];
      mag    = raw;
      e.sign = 1'b0;
`ifdef BIN_BCD_SIGNED_EN
      if (raw[15]) begin
         e.sign = 1'b1;
         mag    = 32'd65536 - raw;
      end
`endif
      e.dato = '0;
      if (mag > 9999) begin
         e.dato = 32'h0000_9999;
         e.ovf  = 1'b1;
      end else begin
         e.ovf = 1'b0;
         t     = mag;
         for (int k = 0; k < 4; k++) begin
            e.dato[4*k +: 4] = 4'(t % 10);
            t = t / 10;
         end
      end
      return e;
   endfunction

   // Compare every delivered result against the head of the scoreboard.
   always @(negedge clk) begin
      if (rst_n && bif.we_o) begin
         if (q.size() == 0) begin
            check("unexpected_we", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = q.pop_front();
            check("dato_o", bif.dato_o, e.dato);
            check("ovf_o", {31'd0, bif.ovf_o}, {31'd0, e.ovf});
            check("sign_o", {31'd0, bif.sign_o}, {31'd0, e.sign});
         end
      end
   end

   task automatic write(input logic [31:0] v, input bit expect_result);
      @(negedge clk);
      bif.dato_i = v;
      bif.we_i   = 1'b1;
      if (expect_result) q.push_back(model(v));
      @(negedge clk);
      bif.we_i = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((q.size() != 0 || bif.busy_o) && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("idle_timeout", {31'd0, n >= 200}, 32'd0);
      @(negedge clk);
   endtask

   initial begin
      int busy_cnt;
      int we_cnt;
      int n;
      errors     = 0;
      checks     = 0;
      rst_n      = 1'b0;
      bif.dato_i = '0;
      bif.we_i   = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_dato", bif.dato_o, 32'd0);
      check("rst_we", {31'd0, bif.we_o}, 32'd0);
      check("rst_busy", {31'd0, bif.busy_o}, 32'd0);
      check("rst_ovf", {31'd0, bif.ovf_o}, 32'd0);
      check("rst_sign", {31'd0, bif.sign_o}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // 1234: busy across the 17 cycles before the strobe, strobe on the 18th negedge
      write(32'h0000_04D2, 1'b1);
      busy_cnt = 0;
      we_cnt   = 0;
      for (int i = 0; i < 17; i++) begin
         if (bif.busy_o) busy_cnt++;
         if (bif.we_o) we_cnt++;
         @(negedge clk);
      end
      check("busy_cycles", busy_cnt, 32'd17);
      check("early_we", we_cnt, 32'd0);
      check("latency_we", {31'd0, bif.we_o}, 32'd1);
      @(negedge clk);
      check("we_one_cycle", {31'd0, bif.we_o}, 32'd0);
      repeat (5) @(negedge clk);
      check("dato_hold", bif.dato_o, 32'h0000_1234);
      check("busy_after", {31'd0, bif.busy_o}, 32'd0);

      // Saturation boundary and zero
      write(32'd9999, 1'b1);  wait_idle();
      write(32'd10000, 1'b1); wait_idle();
      write(32'd0, 1'b1);     wait_idle();
      write(32'hABCD_0005, 1'b1); wait_idle();
      write(32'd65535, 1'b1); wait_idle();
      write(32'h0000_FFD3, 1'b1); wait_idle();
      write(32'h0000_8000, 1'b1); wait_idle();

      // Latest pending write wins: 7 is overwritten by 815
      write(32'd42, 1'b1);
      repeat (3) @(negedge clk);
      write(32'd7, 1'b0);
      write(32'd815, 1'b1);
      wait_idle();

      // Store arriving in the DONE cycle is converted next
      write(32'd100, 1'b1);
      n = 0;
      while (!bif.we_o && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("done_wait", {31'd0, n < 100}, 32'd1);
      bif.dato_i = 32'd321;
      bif.we_i   = 1'b1;
      q.push_back(model(32'd321));
      @(negedge clk);
      bif.we_i = 1'b0;
      wait_idle();

      // Random values
      for (int i = 0; i < 6; i++) begin
         write($urandom_range(0, 20000), 1'b1);
         wait_idle();
      end

      // Reset in the middle of converting 4321: no strobe, outputs cleared
      write(32'd4321, 1'b0);
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort_busy", {31'd0, bif.busy_o}, 32'd0);
      check("abort_dato", bif.dato_o, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      we_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bif.we_o) we_cnt++;
      end
      check("abort_we", we_cnt, 32'd0);
      check("abort_dato_end", bif.dato_o, 32'd0);
      check("abort_busy_end", {31'd0, bif.busy_o}, 32'd0);
      check("abort_ovf", {31'd0, bif.ovf_o}, 32'd0);
      check("queue_empty", q.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/bin_a_bcd_display.md
Name: bin_a_bcd_display

Overview:
- Sequential binary-to-BCD converter placed directly upstream of the 7-segment display peripheral.
- Accepts a binary word written by the RISC-V bus store path, converts it with shift-add-3 (double dabble), one bit per clock.
- Emits a one-cycle write strobe with the packed BCD word, so the display shows decimal digits instead of hex.
- Saturates and flags values that do not fit in the configured digit count.

Parameters:
WIDTH_IN, 16, number of binary input bits converted (LSBs of dato_i); legal range 4..32
DIGITS, 4, number of BCD digits delivered on dato_o; 4*DIGITS <= 32

Ports:
clk_i  input  1  system clock, all logic on rising edge
reset_n_i  input  1  asynchronous, active-low reset
dato_i  input  32  binary value from bus; bits [WIDTH_IN-1:0] used
we_i  input  1  bus write strobe, one cycle per store
dato_o  output  32  packed BCD result, digit k at [4k+3:4k], bits above 4*DIGITS zero; feeds display dato_i
we_o  output  1  one-cycle strobe when dato_o is valid; feeds display we_i
busy_o  output  1  high while a conversion is in progress (states SHIFT and DONE)
ovf_o  output  1  high when the last delivered result was saturated
sign_o  output  1  sign of last delivered result (see Optional Feature); 0 without the macro

Behaviour:
- Reset (reset_n_i low, asynchronous): state IDLE, dato_o=0, we_o=0, busy_o=0, ovf_o=0, sign_o=0, pending buffer empty, shift counter=0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE: if we_i=1 or pending valid, load the operand (we_i has priority; pending is cleared when it is the source), clear the BCD scratch, counter=0, go to SHIFT.
- SHIFT: each cycle, add 3 to every scratch BCD digit >=5, then shift {scratch, operand} left by one; counter++. After exactly WIDTH_IN shift cycles go to DONE.
- Scratch width: ceil(WIDTH_IN/3)+1 digits, so no intermediate truncation.
- DONE, entry edge:
  - If any scratch digit at index >= DIGITS is nonzero, dato_o=all-9s in DIGITS digits and ovf_o=1.
  - Otherwise dato_o=low DIGITS digits and ovf_o=0.
- DONE, during the cycle: we_o=1 for exactly this one cycle; next state IDLE.
- Latency: we_i sampled on edge E0 gives we_o high in the cycle after edge E0+WIDTH_IN+1. Default is 17 cycles; 18 edges minimum between back-to-back results.
- we_i while busy: the value is captured into a one-deep pending buffer. A newer write overwrites an older pending value (latest wins). A pending value starts conversion on the first IDLE cycle.
- we_i in DONE cycle: captured into pending, converted next.
- dato_o, ovf_o, sign_o hold their values between DONE cycles; they change only on DONE entry.
- Reset mid-conversion: conversion aborted, pending dropped, no we_o pulse, all outputs return to reset values.
- Input 0 produces dato_o=0, ovf_o=0.

Optional Feature:
- Macro: BIN_BCD_SIGNED_EN.
- Defined:
  - dato_i[WIDTH_IN-1:0] is two's complement; the magnitude (negated if MSB=1) is converted.
  - sign_o = input MSB, registered on DONE entry.
  - Most-negative value converts its magnitude normally (e.g. -32768 becomes magnitude 32768, saturating under default parameters).
- Undefined:
  - Input is unsigned.
  - sign_o tied 0.
  - No negation logic is synthesized.

Test Plan:
- Reset, then we_i=1 with dato_i=0x000004D2 (1234) -> we_o high exactly once, 17 cycles later; dato_o=0x00001234, ovf_o=0, busy_o high for the 17 intervening cycles.
- dato_i=9999 -> dato_o=0x00009999, ovf_o=0; then dato_i=10000 -> dato_o=0x00009999, ovf_o=1; then dato_i=0 -> dato_o=0, ovf_o=0.
- Start conversion of 42, then writes of 7 and 815 during SHIFT -> two we_o pulses only: first 0x00000042, second 0x00000815; 7 never appears.
- Drop reset_n_i low 5 cycles into converting 4321, release, wait 40 cycles -> no we_o pulse, dato_o=0, busy_o=0.
- Only the upper 16 bits of dato_i nonzero (0xABCD0005, WIDTH_IN=16) -> dato_o=0x00000005.
- BIN_BCD_SIGNED_EN defined, dato_i=0x0000FFD3 (-45) -> dato_o=0x00000045, sign_o=1, ovf_o=0; 0x00008000 -> dato_o=0x00009999, sign_o=1, ovf_o=1.
